// File: rtl/aes_pkg.sv
// Shared constants and types for the AES-128 round key store.
//   TYPE_KEY  : key_in_type value that marks a cipher-key load
//   KEY_W     : width of one round key
//   NUM_KEYS  : number of stored round keys (0..NUM_KEYS-1)
//   ADDR_W    : width of key_addr / rd_addr
//   state_t   : fill-tracking FSM encoding
package aes_pkg;
    localparam logic [1:0] TYPE_KEY = 2'b10;
    localparam int KEY_W    = 128;
    localparam int NUM_KEYS = 11;
    localparam int ADDR_W   = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        READY   = 2'd2,
        ERROR   = 2'd3
    } state_t;
endpackage

// File: rtl/round_key_store_if.sv
// Bundle of the key-load, expansion-write and read-port signals.
//   master : side that drives loads, expansion writes and read requests
//   slave  : the round key store itself
interface round_key_store_if;
    import aes_pkg::*;

    logic              key_in_valid;
    logic [1:0]        key_in_type;
    logic [KEY_W-1:0]  key_in;
    logic [KEY_W-1:0]  key_out;
    logic [ADDR_W-1:0] key_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [KEY_W-1:0]  rd_data;
    logic              rd_valid;
    logic              rd_err;
    logic              keys_ready;
    logic              seq_err;

    modport master (
        output key_in_valid, key_in_type, key_in, key_out, key_addr, rd_en, rd_addr,
        input  rd_data, rd_valid, rd_err, keys_ready, seq_err
    );

    modport slave (
        input  key_in_valid, key_in_type, key_in, key_out, key_addr, rd_en, rd_addr,
        output rd_data, rd_valid, rd_err, keys_ready, seq_err
    );
endinterface

// File: rtl/round_key_regfile.sv
// NUM_KEYS x KEY_W round key storage, one write port, one registered read port.
//   clk, rst_n        : clock, async active-low reset (read register only)
//   we/wr_addr/wr_data: write port
//   rd_en/rd_addr     : read request
//   rd_hit            : address is in range and holds a written key
//   rd_data           : registered read data, 0 on a miss, held when idle
module round_key_regfile
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [KEY_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic              rd_hit,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [KEY_W-1:0]  rd_data
);
    // Storage is not reset; the valid bitmap in the top guards every read.
    logic [KEY_W-1:0] mem [NUM_KEYS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_hit ? mem[rd_addr] : '0;
        end
    end
endmodule

// File: rtl/round_key_store.sv
// Captures the cipher key and the expanded round keys 1..NUM_KEYS-1 from the
// key expansion stage and serves them through a registered random-access port.
//   clk, rst_n : clock, async active-low reset
//   bus        : load / expansion-write / read signals (slave side)
//
//   state   | meaning
//   EMPTY   | nothing loaded, key_addr ignored
//   FILLING | key 0 stored, accepting key_addr == expected in order
//   READY   | all keys stored, key_addr ignored
//   ERROR   | out-of-order key_addr seen, waiting for a new load
module round_key_store
    import aes_pkg::*;
(
    input logic              clk,
    input logic              rst_n,
    round_key_store_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_KEYS - 1);

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]   expected_q, expected_d;
    logic                rd_valid_q, rd_err_q;

    logic                load;
    logic                we;
    logic [ADDR_W-1:0]   wr_addr;
    logic [KEY_W-1:0]    wr_data;
    logic                rd_hit;
    logic [2**ADDR_W-1:0] valid_ext;

    assign load = bus.key_in_valid && (bus.key_in_type == TYPE_KEY);

    // Hit uses the pre-edge bitmap, so a read colliding with a write misses.
    assign valid_ext = (2**ADDR_W)'(valid_q);
    assign rd_hit    = (bus.rd_addr < ADDR_W'(NUM_KEYS)) && valid_ext[bus.rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            valid_q    <= '0;
            expected_q <= ADDR_W'(1);
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            expected_q <= expected_d;
            rd_valid_q <= bus.rd_en;
            rd_err_q   <= bus.rd_en && !rd_hit;
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        expected_d = expected_q;
        we         = 1'b0;
        wr_addr    = '0;
        wr_data    = bus.key_out;

        if (load) begin
            // A load wins over any simultaneous expansion write.
            state_d    = FILLING;
            valid_d    = NUM_KEYS'(1);
            expected_d = ADDR_W'(1);
            we         = 1'b1;
            wr_data    = bus.key_in;
        end else if (state_q == FILLING && bus.key_addr != '0) begin
            if (bus.key_addr == expected_q) begin
                we         = 1'b1;
                wr_addr    = expected_q;
                valid_d    = valid_q | (NUM_KEYS'(1) << expected_q);
                expected_d = expected_q + ADDR_W'(1);
                if (expected_q == LAST_IDX) begin
                    state_d = READY;
                end
            end else begin
                state_d = ERROR;
            end
        end
    end

    round_key_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (bus.rd_en),
        .rd_hit  (rd_hit),
        .rd_addr (bus.rd_addr),
        .rd_data (bus.rd_data)
    );

    // Status flags decode straight from the state register, so they change
    // on the same edge as the transition and clear asynchronously on reset.
    assign bus.keys_ready = (state_q == READY);
    assign bus.seq_err    = (state_q == ERROR);
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
endmodule

// File: tb/tb_round_key_store.sv
// Directed self-checking bench for round_key_store with a read scoreboard.
module tb_round_key_store;
    import aes_pkg::*;

    typedef struct {
        int               addr;
        logic             err;
        logic [KEY_W-1:0] data;
    } exp_t;

    localparam logic [KEY_W-1:0] K0   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [KEY_W-1:0] ONES = {KEY_W{1'b1}};

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    exp_t q[$];
    logic [KEY_W-1:0] last_data;

    round_key_store_if bus ();

    round_key_store dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [KEY_W-1:0] kv(input int i);
        return {4{32'hC0DE0000 + 32'(i)}};
    endfunction

    task automatic chk(input string tag, input logic [KEY_W-1:0] obs, input logic [KEY_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int addr, input logic err, input logic [KEY_W-1:0] data);
        exp_t e;
        e.addr = addr;
        e.err  = err;
        e.data = data;
        bus.rd_en   = 1'b1;
        bus.rd_addr = ADDR_W'(addr);
        q.push_back(e);
    endtask

    // One clock: sample #1 after the edge, score the read port, clear strobes.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        chk("rd_valid", KEY_W'(bus.rd_valid), KEY_W'(q.size() > 0));
        if (q.size() > 0) begin
            e = q.pop_front();
            chk($sformatf("rd_err[%0d]", e.addr), KEY_W'(bus.rd_err), KEY_W'(e.err));
            chk($sformatf("rd_data[%0d]", e.addr), bus.rd_data, e.data);
            last_data = e.data;
        end else begin
            chk("rd_err_idle", KEY_W'(bus.rd_err), '0);
            chk("rd_data_hold", bus.rd_data, last_data);
        end
        bus.key_in_valid = 1'b0;
        bus.key_addr     = '0;
        bus.rd_en        = 1'b0;
    endtask

    task automatic load(input logic [KEY_W-1:0] key);
        bus.key_in_valid = 1'b1;
        bus.key_in_type  = TYPE_KEY;
        bus.key_in       = key;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_data = '0;
        bus.key_in_valid = 1'b0;
        bus.key_in_type  = 2'b00;
        bus.key_in       = '0;
        bus.key_out      = '0;
        bus.key_addr     = '0;
        bus.rd_en        = 1'b0;
        bus.rd_addr      = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_keys_ready", KEY_W'(bus.keys_ready), '0);
        chk("rst_seq_err", KEY_W'(bus.seq_err), '0);
        chk("rst_rd_valid", KEY_W'(bus.rd_valid), '0);
        chk("rst_rd_data", bus.rd_data, '0);
        tick();
        #2 rst_n = 1'b1;

        // key_addr before any load is ignored
        bus.key_addr = 4'd1; bus.key_out = kv(1);
        tick();
        rd(1, 1'b1, '0);
        tick();

        // normal fill with early/collision reads
        load(K0);
        tick();
        chk("fill_ready0", KEY_W'(bus.keys_ready), '0);
        for (int i = 1; i <= 10; i++) begin
            bus.key_addr = ADDR_W'(i);
            bus.key_out  = kv(i);
            if (i == 2) rd(2, 1'b1, '0);
            if (i == 4) rd(5, 1'b1, '0);
            if (i == 5) rd(11, 1'b1, '0);
            if (i == 7) rd(3, 1'b0, kv(3));
            tick();
            chk($sformatf("fill_ready_%0d", i), KEY_W'(bus.keys_ready), KEY_W'(i == 10));
        end
        chk("fill_seq_err", KEY_W'(bus.seq_err), '0);

        // key_addr in READY neither rewrites nor errors
        bus.key_addr = 4'd3; bus.key_out = ONES;
        tick();
        chk("ready_ign_seq", KEY_W'(bus.seq_err), '0);
        chk("ready_ign_rdy", KEY_W'(bus.keys_ready), KEY_W'(1));

        for (int i = 0; i <= 10; i++) begin
            rd(i, 1'b0, (i == 0) ? K0 : kv(i));
            tick();
        end
        // decrypt order, back to back
        for (int i = 10; i >= 0; i--) begin
            rd(i, 1'b0, (i == 0) ? K0 : kv(i));
            tick();
        end
        tick();

        // reload with coincident key_addr=4 and a read of old key 0
        load(ONES);
        bus.key_addr = 4'd4; bus.key_out = kv(44);
        rd(0, 1'b0, K0);
        tick();
        chk("reload_ready", KEY_W'(bus.keys_ready), '0);
        rd(1, 1'b1, '0);  tick();
        rd(0, 1'b0, ONES); tick();
        rd(4, 1'b1, '0);  tick();

        // out of order
        bus.key_addr = 4'd1; bus.key_out = kv(21);
        tick();
        bus.key_addr = 4'd3; bus.key_out = kv(23);
        tick();
        chk("ooo_seq_err", KEY_W'(bus.seq_err), KEY_W'(1));
        chk("ooo_ready", KEY_W'(bus.keys_ready), '0);
        rd(3, 1'b1, '0);   tick();
        rd(1, 1'b0, kv(21)); tick();
        bus.key_addr = 4'd2; bus.key_out = kv(22);
        tick();
        chk("err_hold", KEY_W'(bus.seq_err), KEY_W'(1));
        rd(2, 1'b1, '0); tick();
        load(K0);
        tick();
        chk("err_clear", KEY_W'(bus.seq_err), '0);
        rd(1, 1'b1, '0); tick();

        // reset mid-fill
        for (int i = 1; i <= 6; i++) begin
            bus.key_addr = ADDR_W'(i);
            bus.key_out  = kv(i + 30);
            if (i == 6) rd(3, 1'b0, kv(33));
            tick();
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_valid", KEY_W'(bus.rd_valid), '0);
        chk("mid_rst_rd_data", bus.rd_data, '0);
        chk("mid_rst_seq_err", KEY_W'(bus.seq_err), '0);
        chk("mid_rst_ready", KEY_W'(bus.keys_ready), '0);
        last_data = '0;
        #3 rst_n = 1'b1;
        bus.key_addr = 4'd7; bus.key_out = kv(37);
        tick();
        bus.key_addr = 4'd1; bus.key_out = kv(41);
        tick();
        rd(1, 1'b1, '0); tick();
        rd(0, 1'b1, '0); tick();
        chk("post_rst_ready", KEY_W'(bus.keys_ready), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/round_key_store.md
Name: round_key_store

Overview:
- Sits directly downstream of the AES-128 key expansion stage.
- Captures the cipher key (round key 0) when a key load is accepted, then stores round keys 1..10 as the expansion stage presents them on key_out/key_addr.
- Provides a registered random-access read port to the cipher round datapath, so encrypt (0..10) and decrypt (10..0) sequencing can both use it.
- Small FSM tracks fill progress, in-order arrival and the ready status.

Parameters:
- KEY_W, 128, width of one round key.
- NUM_KEYS, 11, number of stored keys (indices 0..NUM_KEYS-1).
- ADDR_W, 4, width of key_addr/rd_addr.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key_in_valid  in  1  load strobe, same signal the expansion stage sees.
- key_in_type  in  2  load type; 2'b10 = key.
- key_in  in  KEY_W  cipher key, stored as round key 0.
- key_out  in  KEY_W  round key from expansion stage; valid in any cycle where key_addr != 0.
- key_addr  in  ADDR_W  index of key_out (1..10); 0 = no key this cycle.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  key index to read.
- rd_data  out  KEY_W  read data, registered.
- rd_valid  out  1  rd_data/rd_err valid; one-cycle pulse.
- rd_err  out  1  read addressed an out-of-range or not-yet-written key.
- keys_ready  out  1  all NUM_KEYS keys stored, level.
- seq_err  out  1  sticky out-of-order key_addr detected.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All outputs 0.
  - FSM = EMPTY; valid bitmap = 0; expected index = 1.
  - Key storage need not be reset.
- Load accept: key_in_valid & key_in_type==2'b10.
  - Honoured in every state; a load always wins over a simultaneous write.
  - Actions: mem[0] <= key_in; valid <= 11'b1; expected <= 1; seq_err <= 0; keys_ready <= 0; FSM -> FILLING.
- FSM states:
  - EMPTY: key_addr ignored; only a load accept leaves the state.
  - FILLING:
    - key_addr==0: no action.
    - key_addr==expected: mem[expected] <= key_out; valid[expected] <= 1; expected++.
    - If expected was 10: FSM -> READY and keys_ready <= 1 on the same edge.
    - key_addr != 0 and != expected: no write; seq_err <= 1; FSM -> ERROR.
  - READY: keys_ready=1; key_addr activity ignored (no rewrite, no error).
  - ERROR: keys_ready=0; seq_err held at 1; only a load accept leaves the state.
- Read port, latency 1:
  - On rd_en at edge N, rd_valid=1 for cycle N+1 only.
  - If rd_addr < NUM_KEYS and valid[rd_addr]: rd_data=mem[rd_addr], rd_err=0.
  - Otherwise: rd_data=0, rd_err=1.
  - rd_en=0: rd_valid=0 and rd_err=0; rd_data holds its last value.
- Read/write collision on the same edge to the same index: read samples the pre-write valid bit and contents, so the read returns rd_err=1.
- Read during a load accept: uses pre-load state, so rd_addr 0 returns the old key 0 if it was valid.
- Back-to-back reads: one per cycle, fully pipelined, no stall.
- Reset mid-fill: all state is discarded; a new load is required.

Decomposition:
- Shared package aes_pkg holds:
  - TYPE_KEY = 2'b10
  - KEY_W = 128, NUM_KEYS = 11, ADDR_W = 4
  - FSM state encoding: EMPTY, FILLING, READY, ERROR.
- One natural sub-module: round_key_regfile, holding the 11 x 128 storage with one write port and one registered read port.
- FSM, valid bitmap and error logic stay in the top module.

Test Plan:
- Normal fill: load key 0x000102...0F, then key_addr 1..10 on consecutive cycles with distinct key_out.
  - keys_ready rises on the edge that writes key 10.
  - Reads of 0..10 return the exact stored values; rd_err=0.
- Early read: during FILLING after keys 1..3, rd_addr=5 -> rd_valid=1, rd_err=1, rd_data=0.
  - rd_addr=11 -> rd_err=1.
  - rd_addr=2 in the same cycle key 2 is written -> rd_err=1.
- Out of order: after load, key_addr=1 then key_addr=3.
  - seq_err=1, FSM=ERROR, keys_ready=0, mem[3] unwritten.
  - A new load clears seq_err.
- Reload: while READY, load new key 0xFF..FF.
  - keys_ready=0 the next cycle; rd_addr=1 -> rd_err=1.
  - rd_addr=0 -> 0xFF..FF.
  - Load coincident with key_addr=4 -> no write at index 4.
- Reset mid-fill: rst_n low after key 6 -> all outputs 0 immediately (asynchronous); subsequent key_addr writes ignored until a load.
- Decrypt order: with READY, rd_en every cycle with rd_addr 10..0 -> 11 consecutive rd_valid pulses with matching data, no gaps.
